// File: rtl/pacman_game_pkg.sv
// Shared types and constants for the pacman game-state sequencer.
// Score arithmetic saturates at the 11-bit display limit.
package pacman_game_pkg;

  typedef enum logic [1:0] {
    READY,
    PLAY,
    DYING,
    GAME_OVER
  } game_state_t;

  localparam logic [1:0] GH_RED   = 2'd0;
  localparam logic [1:0] GH_GREEN = 2'd1;
  localparam logic [1:0] GH_AQUA  = 2'd2;

  localparam int unsigned TIMER_W   = 10;
  localparam logic [10:0] SCORE_MAX = 11'd2047;

  function automatic logic [10:0] score_add(input logic [10:0] score, input logic [11:0] inc);
    logic [11:0] sum;
    sum = {1'b0, score} + inc;
    return (sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : sum[10:0];
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame-granular timer: load has priority over tick. Down mode stops at zero,
// up mode saturates at all-ones. done flags a zero count.
module frame_timer #(
  parameter int unsigned WIDTH    = 10,
  parameter bit          COUNT_UP = 1'b0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             done
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (tick) begin
      if (COUNT_UP) begin
        if (count_q != '1) count_d = count_q + WIDTH'(1);
      end else if (count_q != '0) begin
        count_d = count_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;
  assign done  = (count_q == '0);

endmodule

// File: rtl/game_state_sequencer.sv
// Frame-driven game controller feeding the colour mapper: game phase, ghost
// release/respawn, power-pellet reversal, mouth animation, score and lives.
module game_state_sequencer
  import pacman_game_pkg::*;
#(
  parameter int unsigned READY_FRAMES    = 120,
  parameter int unsigned DYING_FRAMES    = 90,
  parameter int unsigned REVERSAL_FRAMES = 360,
  parameter int unsigned RESPAWN_FRAMES  = 180,
  parameter int unsigned MOUTH_FRAMES    = 8,
  parameter int unsigned RELEASE_GREEN   = 180,
  parameter int unsigned RELEASE_AQUA    = 360,
  parameter int unsigned DOT_POINTS      = 1,
  parameter int unsigned FRUIT_POINTS    = 10,
  parameter int unsigned GHOST_POINTS    = 20,
  parameter int unsigned START_LIVES     = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        dot_eaten,
  input  logic        fruit_eaten,
  input  logic        power_eaten,
  input  logic [2:0]  ghost_hit,
  input  logic        all_dots_cleared,
  output logic        death,
  output logic        reversal,
  output logic        red_enable,
  output logic        green_enable,
  output logic        aqua_enable,
  output logic        closePacman,
  output logic        freeze,
  output logic [10:0] score,
  output logic [1:0]  lives
);

  localparam logic [TIMER_W-1:0] READY_LAST = TIMER_W'(READY_FRAMES - 1);
  localparam logic [TIMER_W-1:0] DYING_LAST = TIMER_W'(DYING_FRAMES - 1);
  localparam logic [TIMER_W-1:0] REV_LOAD   = TIMER_W'(REVERSAL_FRAMES);
  localparam logic [TIMER_W-1:0] RESP_LOAD  = TIMER_W'(RESPAWN_FRAMES);
  localparam logic [TIMER_W-1:0] MOUTH_LOAD = TIMER_W'(MOUTH_FRAMES);
  localparam logic [TIMER_W-1:0] REL_GREEN  = TIMER_W'(RELEASE_GREEN);
  localparam logic [TIMER_W-1:0] REL_AQUA   = TIMER_W'(RELEASE_AQUA);

  game_state_t        state_q, state_d;
  logic [10:0]        score_q, score_d;
  logic [1:0]         lives_q, lives_d;
  logic [TIMER_W-1:0] rel_q, rel_d;
  logic               mouth_q, mouth_d;

  logic               st_load, mouth_load, leave_play;
  logic [TIMER_W-1:0] st_cnt, mouth_cnt, rev_cnt;
  logic               st_done, mouth_done, rev_done;
  logic [TIMER_W-1:0] resp_cnt [3];
  logic [2:0]         resp_done;

  logic               in_play, rev_active, fatal;
  logic [2:0]         eat;
  logic [11:0]        inc;
  logic               unused_timer;

  assign in_play    = (state_q == PLAY);
  assign rev_active = in_play && !rev_done;
  assign fatal      = in_play && (|ghost_hit) && !rev_active;

  always_comb begin
    eat = rev_active ? ghost_hit : 3'b000;
    inc = (dot_eaten ? 12'(DOT_POINTS) : 12'd0) + (fruit_eaten ? 12'(FRUIT_POINTS) : 12'd0)
        + 12'(GHOST_POINTS) * (12'(eat[0]) + 12'(eat[1]) + 12'(eat[2]));
  end

  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    lives_d    = lives_q;
    rel_d      = rel_q;
    mouth_d    = mouth_q;
    st_load    = 1'b0;
    mouth_load = 1'b0;
    leave_play = 1'b0;
    unique case (state_q)
      READY: begin
        if (frame_tick && st_cnt == READY_LAST) begin
          state_d    = PLAY;
          st_load    = 1'b1;
          rel_d      = '0;
          mouth_d    = 1'b0;
          mouth_load = 1'b1;
        end
      end
      PLAY: begin
        score_d = score_add(score_q, inc);
        if (fatal) begin
          state_d    = DYING;
          st_load    = 1'b1;
          leave_play = 1'b1;
        end else if (all_dots_cleared) begin
          state_d    = READY;
          st_load    = 1'b1;
          leave_play = 1'b1;
        end else begin
          if (frame_tick && rel_q < REL_AQUA) rel_d = rel_q + TIMER_W'(1);
          // Reload on the last tick rather than letting the timer reach zero.
          if (frame_tick && mouth_cnt == TIMER_W'(1)) begin
            mouth_load = 1'b1;
            mouth_d    = ~mouth_q;
          end
        end
      end
      DYING: begin
        if (frame_tick && st_cnt == DYING_LAST) begin
          st_load = 1'b1;
          if (lives_q > 2'd1) begin
            lives_d = lives_q - 2'd1;
            state_d = READY;
          end else begin
            lives_d = 2'd0;
            state_d = GAME_OVER;
          end
        end
      end
      GAME_OVER: begin
        if (start) begin
          score_d = '0;
          lives_d = 2'(START_LIVES);
          state_d = READY;
          st_load = 1'b1;
        end
      end
      default: state_d = READY;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= READY;
      score_q <= '0;
      lives_q <= 2'(START_LIVES);
      rel_q   <= '0;
      mouth_q <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      lives_q <= lives_d;
      rel_q   <= rel_d;
      mouth_q <= mouth_d;
    end
  end

  // Counts ticks elapsed in READY/DYING; restarted at every phase change.
  frame_timer #(.WIDTH(TIMER_W), .COUNT_UP(1'b1)) u_state_timer (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (st_load),
    .load_val ('0),
    .tick     (frame_tick && (state_q == READY || state_q == DYING)),
    .count    (st_cnt),
    .done     (st_done)
  );

  frame_timer #(.WIDTH(TIMER_W)) u_reversal_timer (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (leave_play || (in_play && power_eaten)),
    .load_val (leave_play ? '0 : REV_LOAD),
    .tick     (frame_tick && in_play),
    .count    (rev_cnt),
    .done     (rev_done)
  );

  for (genvar g = 0; g < 3; g++) begin : g_respawn
    frame_timer #(.WIDTH(TIMER_W)) u_respawn_timer (
      .Clk      (Clk),
      .Reset    (Reset),
      .load     (leave_play || eat[g]),
      .load_val (leave_play ? '0 : RESP_LOAD),
      .tick     (frame_tick && in_play),
      .count    (resp_cnt[g]),
      .done     (resp_done[g])
    );
  end

  frame_timer #(.WIDTH(TIMER_W)) u_mouth_timer (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (mouth_load),
    .load_val (MOUTH_LOAD),
    .tick     (frame_tick && in_play),
    .count    (mouth_cnt),
    .done     (mouth_done)
  );

  assign unused_timer = ^{st_done, mouth_done, rev_cnt, resp_cnt[0], resp_cnt[1], resp_cnt[2]};

  // Outputs decode registered state only, so there is no input-to-output path.
  assign freeze       = !in_play;
  assign death        = (state_q == GAME_OVER);
  assign reversal     = rev_active;
  assign red_enable   = in_play && resp_done[GH_RED];
  assign green_enable = in_play && (rel_q >= REL_GREEN) && resp_done[GH_GREEN];
  assign aqua_enable  = in_play && (rel_q >= REL_AQUA) && resp_done[GH_AQUA];
  assign closePacman  = in_play ? mouth_q : (state_q == DYING || state_q == GAME_OVER);
  assign score        = score_q;
  assign lives        = lives_q;

endmodule

// File: tb/tb_game_state_sequencer.sv
// Bench for game_state_sequencer: directed vector table, hand-written corner
// sequences, then random traffic checked every cycle against a frame-count model.
module tb_game_state_sequencer;

  localparam int READY_F = 4;
  localparam int DYING_F = 3;
  localparam int REV_F   = 5;
  localparam int RESP_F  = 4;
  localparam int MOUTH_F = 2;
  localparam int REL_G   = 3;
  localparam int REL_A   = 6;

  localparam int M_READY = 0;
  localparam int M_PLAY  = 1;
  localparam int M_DYING = 2;
  localparam int M_OVER  = 3;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_tick = 1'b0, start = 1'b0, dot_eaten = 1'b0, fruit_eaten = 1'b0;
  logic        power_eaten = 1'b0, all_dots_cleared = 1'b0;
  logic [2:0]  ghost_hit = 3'b000;
  logic        death, reversal, red_enable, green_enable, aqua_enable, closePacman, freeze;
  logic [10:0] score;
  logic [1:0]  lives;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model state: phase plus plain frame counts.
  int m_mode, m_elapsed, m_play_ticks, m_rev_left, m_score, m_lives;
  int m_resp [3];

  typedef struct {
    logic [3:0] ev;   // {tick, dot, fruit, power}
    logic [2:0] h;
    logic [2:0] en;   // {aqua, green, red}
    logic       frz;
    logic       rev;
    logic       cls;
    int         sc;
  } vec_t;
  vec_t tab [$];

  always #5 Clk = ~Clk;

  game_state_sequencer #(
    .READY_FRAMES    (READY_F),
    .DYING_FRAMES    (DYING_F),
    .REVERSAL_FRAMES (REV_F),
    .RESPAWN_FRAMES  (RESP_F),
    .MOUTH_FRAMES    (MOUTH_F),
    .RELEASE_GREEN   (REL_G),
    .RELEASE_AQUA    (REL_A)
  ) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .frame_tick       (frame_tick),
    .start            (start),
    .dot_eaten        (dot_eaten),
    .fruit_eaten      (fruit_eaten),
    .power_eaten      (power_eaten),
    .ghost_hit        (ghost_hit),
    .all_dots_cleared (all_dots_cleared),
    .death            (death),
    .reversal         (reversal),
    .red_enable       (red_enable),
    .green_enable     (green_enable),
    .aqua_enable      (aqua_enable),
    .closePacman      (closePacman),
    .freeze           (freeze),
    .score            (score),
    .lives            (lives)
  );

  function automatic void model_reset();
    m_mode = M_READY; m_elapsed = 0; m_play_ticks = 0; m_rev_left = 0;
    m_score = 0; m_lives = 3;
    for (int i = 0; i < 3; i++) m_resp[i] = 0;
  endfunction

  function automatic void model_step(input bit tk, input bit d, input bit f, input bit p,
                                     input logic [2:0] h, input bit c, input bit s);
    int  inc;
    bit  rev;
    case (m_mode)
      M_READY: if (tk) begin
        m_elapsed++;
        if (m_elapsed == READY_F) begin
          m_mode = M_PLAY; m_elapsed = 0; m_play_ticks = 0;
        end
      end
      M_PLAY: begin
        rev = (m_rev_left > 0);
        inc = (d ? 1 : 0) + (f ? 10 : 0);
        if (rev) for (int i = 0; i < 3; i++) if (h[i]) inc += 20;
        m_score = (m_score + inc > 2047) ? 2047 : m_score + inc;
        if (h != 3'b000 && !rev) begin
          m_mode = M_DYING; m_elapsed = 0; m_rev_left = 0;
          for (int i = 0; i < 3; i++) m_resp[i] = 0;
        end else if (c) begin
          m_mode = M_READY; m_elapsed = 0; m_rev_left = 0;
          for (int i = 0; i < 3; i++) m_resp[i] = 0;
        end else begin
          if (tk) begin
            m_play_ticks++;
            if (m_rev_left > 0) m_rev_left--;
            for (int i = 0; i < 3; i++) if (m_resp[i] > 0) m_resp[i]--;
          end
          if (p) m_rev_left = REV_F;
          for (int i = 0; i < 3; i++) if (rev && h[i]) m_resp[i] = RESP_F;
        end
      end
      M_DYING: if (tk) begin
        m_elapsed++;
        if (m_elapsed == DYING_F) begin
          m_elapsed = 0;
          if (m_lives > 1) begin m_lives--; m_mode = M_READY; end
          else begin m_lives = 0; m_mode = M_OVER; end
        end
      end
      default: if (s) begin
        m_score = 0; m_lives = 3; m_mode = M_READY; m_elapsed = 0;
      end
    endcase
  endfunction

  // {death, reversal, aqua, green, red, closePacman, freeze, lives, score}
  function automatic logic [19:0] model_out();
    logic play, cls;
    play = (m_mode == M_PLAY);
    cls  = play ? (((m_play_ticks / MOUTH_F) % 2) == 1) : (m_mode == M_DYING || m_mode == M_OVER);
    return {m_mode == M_OVER, play && m_rev_left > 0,
            play && m_play_ticks >= REL_A && m_resp[2] == 0,
            play && m_play_ticks >= REL_G && m_resp[1] == 0,
            play && m_resp[0] == 0, cls, !play, 2'(m_lives), 11'(m_score)};
  endfunction

  function automatic void cmp_model();
    logic [19:0] got, want;
    got  = {death, reversal, aqua_enable, green_enable, red_enable, closePacman, freeze,
            lives, score};
    want = model_out();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL model cyc=%0d flags got=%b want=%b lives got=%0d want=%0d score got=%0d want=%0d",
               cyc, got[19:13], want[19:13], got[12:11], want[12:11], got[10:0], want[10:0]);
    end
  endfunction

  function automatic void check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
    end
  endfunction

  task automatic step(input bit tk, input bit d, input bit f, input bit p,
                      input logic [2:0] h, input bit c, input bit s);
    frame_tick = tk; dot_eaten = d; fruit_eaten = f; power_eaten = p;
    ghost_hit = h; all_dots_cleared = c; start = s;
    @(posedge Clk);
    model_step(tk, d, f, p, h, c, s);
    #1;
    frame_tick = 1'b0; dot_eaten = 1'b0; fruit_eaten = 1'b0; power_eaten = 1'b0;
    ghost_hit = 3'b000; all_dots_cleared = 1'b0; start = 1'b0;
    cyc++;
    cmp_model();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(posedge Clk);
    model_reset();
    #1;
    Reset = 1'b0;
    cyc++;
    cmp_model();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 3'b000, 0, 0);
  endtask

  function automatic void addv(input logic [3:0] ev, input logic [2:0] h, input logic [2:0] en,
                               input logic frz, input logic rev, input logic cls, input int sc);
    vec_t v;
    v.ev = ev; v.h = h; v.en = en; v.frz = frz; v.rev = rev; v.cls = cls; v.sc = sc;
    tab.push_back(v);
  endfunction

  initial begin
    // Power-up: READY for 4 ticks, then release and mouth cadence.
    addv(4'b1000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 0);
    addv(4'b1000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 0);
    addv(4'b1000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 0);
    addv(4'b1000, 3'b000, 3'b001, 1'b0, 1'b0, 1'b0, 0);
    addv(4'b1000, 3'b000, 3'b001, 1'b0, 1'b0, 1'b0, 0);
    addv(4'b1000, 3'b000, 3'b001, 1'b0, 1'b0, 1'b1, 0);
    addv(4'b1000, 3'b000, 3'b011, 1'b0, 1'b0, 1'b1, 0);
    addv(4'b1000, 3'b000, 3'b011, 1'b0, 1'b0, 1'b0, 0);
    addv(4'b1000, 3'b000, 3'b011, 1'b0, 1'b0, 1'b0, 0);
    addv(4'b1000, 3'b000, 3'b111, 1'b0, 1'b0, 1'b1, 0);
    // Power pellet, two ticks, eat red+aqua, respawn after 4 ticks.
    addv(4'b0001, 3'b000, 3'b111, 1'b0, 1'b1, 1'b1, 0);
    addv(4'b1000, 3'b000, 3'b111, 1'b0, 1'b1, 1'b1, 0);
    addv(4'b1000, 3'b000, 3'b111, 1'b0, 1'b1, 1'b0, 0);
    addv(4'b0000, 3'b101, 3'b010, 1'b0, 1'b1, 1'b0, 40);
    addv(4'b1000, 3'b000, 3'b010, 1'b0, 1'b1, 1'b0, 40);
    addv(4'b1000, 3'b000, 3'b010, 1'b0, 1'b1, 1'b1, 40);
    addv(4'b1000, 3'b000, 3'b010, 1'b0, 1'b0, 1'b1, 40);
    addv(4'b1000, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 40);
    addv(4'b0100, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 41);
    addv(4'b0110, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 52);
    // Second pellet at tick 3 extends reversal to tick 8.
    addv(4'b0001, 3'b000, 3'b111, 1'b0, 1'b1, 1'b0, 52);
    addv(4'b1000, 3'b000, 3'b111, 1'b0, 1'b1, 1'b0, 52);
    addv(4'b1000, 3'b000, 3'b111, 1'b0, 1'b1, 1'b1, 52);
    addv(4'b1000, 3'b000, 3'b111, 1'b0, 1'b1, 1'b1, 52);
    addv(4'b0001, 3'b000, 3'b111, 1'b0, 1'b1, 1'b1, 52);
    addv(4'b1000, 3'b000, 3'b111, 1'b0, 1'b1, 1'b0, 52);
    addv(4'b1000, 3'b000, 3'b111, 1'b0, 1'b1, 1'b0, 52);
    addv(4'b1000, 3'b000, 3'b111, 1'b0, 1'b1, 1'b1, 52);
    addv(4'b1000, 3'b000, 3'b111, 1'b0, 1'b1, 1'b1, 52);
    addv(4'b1000, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 52);

    do_reset();
    check("reset freeze", freeze, 1);
    check("reset lives", lives, 3);
    check("reset score", score, 0);
    check("reset enables", {aqua_enable, green_enable, red_enable}, 0);

    foreach (tab[i]) begin
      step(tab[i].ev[3], tab[i].ev[2], tab[i].ev[1], tab[i].ev[0], tab[i].h, 0, 0);
      check($sformatf("v%0d enables", i), {aqua_enable, green_enable, red_enable}, tab[i].en);
      check($sformatf("v%0d freeze", i), freeze, tab[i].frz);
      check($sformatf("v%0d reversal", i), reversal, tab[i].rev);
      check($sformatf("v%0d close", i), closePacman, tab[i].cls);
      check($sformatf("v%0d score", i), score, tab[i].sc);
    end

    // Fatal hit, then run out of lives.
    step(0, 0, 0, 0, 3'b010, 0, 0);
    check("die freeze", freeze, 1);
    check("die close", closePacman, 1);
    check("die score", score, 52);
    ticks(2);
    check("dying lives", lives, 3);
    ticks(1);
    check("lost life", lives, 2);
    check("lost freeze", freeze, 1);
    for (int l = 2; l >= 1; l--) begin
      ticks(READY_F);
      check("replay freeze", freeze, 0);
      step(0, 0, 0, 0, 3'b010, 0, 0);
      ticks(DYING_F);
      check("lives left", lives, l - 1);
    end
    check("game over death", death, 1);
    step(1, 1, 1, 1, 3'b000, 0, 0);
    check("over ignores dot", score, 52);
    check("over freeze", freeze, 1);
    step(0, 0, 0, 0, 3'b000, 0, 1);
    check("start score", score, 0);
    check("start lives", lives, 3);
    check("start death", death, 0);

    // Score saturation.
    ticks(READY_F);
    for (int i = 0; i < 204; i++) step(0, 0, 1, 0, 3'b000, 0, 0);
    check("score 2040", score, 2040);
    step(0, 1, 1, 0, 3'b000, 0, 0);
    check("score sat", score, 2047);
    step(0, 1, 0, 0, 3'b000, 0, 0);
    check("score held", score, 2047);

    // Level clear keeps score and lives.
    step(0, 0, 0, 0, 3'b000, 1, 0);
    check("clear freeze", freeze, 1);
    check("clear close", closePacman, 0);
    check("clear lives", lives, 3);
    ticks(READY_F);
    check("clear replay", freeze, 0);

    // Level clear with a fatal hit: DYING wins.
    step(0, 0, 0, 0, 3'b001, 1, 0);
    check("clr+hit close", closePacman, 1);
    ticks(DYING_F);
    check("clr+hit lives", lives, 2);

    // Reset in the middle of DYING.
    ticks(READY_F);
    step(0, 0, 0, 0, 3'b100, 0, 0);
    step(1, 0, 0, 0, 3'b000, 0, 0);
    check("mid dying lives", lives, 2);
    do_reset();
    check("rst lives", lives, 3);
    check("rst score", score, 0);
    check("rst freeze", freeze, 1);
    check("rst close", closePacman, 0);

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      logic [2:0] h;
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        h = ($urandom_range(0, 24) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
        step($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
             $urandom_range(0, 14) == 0, h, $urandom_range(0, 79) == 0,
             $urandom_range(0, 7) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_state_sequencer.md
Name: game_state_sequencer

Overview:
Frame-driven game controller that produces the mode and status inputs of the colour mapper: death, reversal, red_enable/green_enable/aqua_enable, closePacman, score and lives. It also drives a freeze output to the movement logic. It consumes one-cycle event pulses from the collision and dot-tracking logic, and counts time in frames using frame_tick, a one-cycle pulse per vsync. It sits between the collision/dot logic and the colour mapper.

Parameters:
READY_FRAMES, 120, frames spent in READY before PLAY
DYING_FRAMES, 90, frames spent in DYING
REVERSAL_FRAMES, 360, power-pellet duration in frames
RESPAWN_FRAMES, 180, frames an eaten ghost stays disabled
MOUTH_FRAMES, 8, frames per closePacman toggle
RELEASE_GREEN, 180, PLAY frames before green is enabled (red is enabled at PLAY entry)
RELEASE_AQUA, 360, PLAY frames before aqua is enabled
DOT_POINTS / FRUIT_POINTS / GHOST_POINTS, 1 / 10 / 20, score increments
START_LIVES, 3, lives loaded at reset and at a new game (1..3)

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high
frame_tick  in  1  one-cycle pulse per frame
start  in  1  pulse; starts a new game from GAME_OVER
dot_eaten  in  1  pulse
fruit_eaten  in  1  pulse
power_eaten  in  1  pulse; (re)loads the reversal timer
ghost_hit  in  3  bit0 red, bit1 green, bit2 aqua; pacman overlaps an enabled ghost
all_dots_cleared  in  1  level
death  out  1  game-over display select
reversal  out  1  ghosts frightened
red_enable, green_enable, aqua_enable  out  1 each
closePacman  out  1  mouth-closed frame
freeze  out  1  halts pacman and ghost motion
score  out  11  saturating score
lives  out  2  remaining lives

Behaviour:
- All outputs are registered. Every event is processed in the cycle it arrives; outputs update on the next edge (latency 1).
- Reset values: state=READY, score=0, lives=START_LIVES, death=0, reversal=0, all enables=0, closePacman=0, freeze=1, all timers=0.
- States:
  - READY
    - freeze=1, enables=0.
    - Counts READY_FRAMES ticks, then goes to PLAY.
    - On entry to PLAY: freeze=0, release counter=0, red_enable=1.
  - PLAY
    - The release counter increments on each tick and saturates at RELEASE_AQUA.
    - green_enable is set when the counter reaches RELEASE_GREEN; aqua_enable is set when it reaches RELEASE_AQUA, in both cases unless that ghost is respawning.
    - closePacman toggles every MOUTH_FRAMES ticks.
  - DYING
    - freeze=1, closePacman=1, reversal cleared, enables=0.
    - After DYING_FRAMES ticks:
      - lives>1: lives decrements and the state goes to READY.
      - lives==1: lives=0, death=1, state goes to GAME_OVER.
  - GAME_OVER
    - death=1, freeze=1; all events are ignored.
    - start: score=0, lives=START_LIVES, death=0, state goes to READY.
- Events in PLAY only; dot, fruit, power and hit pulses are ignored in every other state.
- Score
  - Score adds the sum of all concurrent increments: DOT, FRUIT, and GHOST_POINTS per eaten ghost.
  - Computed 12-bit, saturates at 2047.
- power_eaten: reversal=1 and the reversal timer reloads to REVERSAL_FRAMES; a reload while active restarts the timer.
- When the reversal timer reaches 0, reversal is cleared.
- ghost_hit with reversal=1:
  - Each set bit disables that ghost and loads its RESPAWN_FRAMES timer.
  - When that timer expires, the ghost re-enables if its release condition is met.
- ghost_hit with reversal=0 (any bit set): state goes to DYING and score events in the same cycle are still applied.
- all_dots_cleared in PLAY: state goes to READY; score and lives are kept; reversal and respawn timers are cleared. If a fatal ghost_hit arrives in the same cycle, DYING takes priority.
- Timers decrement only on frame_tick. A tick coinciding with a state transition is consumed by the new state's timer load; it does not decrement.
- Reset asserted at any point, including mid-DYING or mid-reversal, restores the reset values on the next edge.

Decomposition:
- Package pacman_game_pkg holds:
  - game_state_t enum (READY, PLAY, DYING, GAME_OVER)
  - ghost index constants (GH_RED=0, GH_GREEN=1, GH_AQUA=2)
  - SCORE_MAX=2047
- Sub-module frame_timer (WIDTH param; load, load_val, tick; count, done) is instanced for:
  - the state timer
  - the reversal timer
  - 3 respawn timers
  - the mouth timer

Test Plan (bench overrides READY=4, DYING=3, REVERSAL=5, RESPAWN=4, MOUTH=2, RELEASE_GREEN=3, RELEASE_AQUA=6):
- Reset, then 4 ticks: freeze 1→0 and red_enable=1. After 3 more ticks green_enable=1; after 6 ticks aqua_enable=1. closePacman toggles every 2 ticks.
- In PLAY, dot+fruit pulsed in the same cycle from score=2040: score=2047. A further dot leaves score at 2047.
- power_eaten, then ghost_hit=3'b101 after 2 ticks: score +40, red/aqua disabled for 4 ticks then re-enabled. Reversal drops 5 ticks after the pulse. A second power_eaten at tick 3 extends reversal to tick 8.
- ghost_hit=3'b010 with reversal=0, lives=3: DYING with freeze=1, 3 ticks later lives=2 and state READY. Repeat until lives=1 → lives=0, death=1. A dot_eaten in GAME_OVER leaves score unchanged. start → score=0, lives=3, death=0.
- all_dots_cleared and a fatal ghost_hit in the same cycle: DYING is entered, not READY.
- Reset mid-DYING at lives=2: next cycle lives=3, score=0, state READY, freeze=1.
